// File: rtl/force_release_pkg.sv
// Shared command, status and sequencing types for the force/release responder.
package force_release_pkg;

  typedef enum logic [1:0] {
    OP_FORCE   = 2'd0,
    OP_RELEASE = 2'd1,
    OP_READ    = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BAD_IDX = 2'd1,
    ST_BAD_OP  = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/force_release_ctrl_cell.sv
// One forceable register: functional storage, force override and the
// post-release hold used for variable-style release semantics.
module forceable_reg_cell #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned REG_SEMANTICS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             func_en,
  input  logic [WIDTH-1:0] func_d,
  input  logic             force_set,
  input  logic [WIDTH-1:0] force_val,
  input  logic             release_cmd,
  output logic [WIDTH-1:0] q,
  output logic             forced,
  output logic [WIDTH-1:0] underlying
);

  logic [WIDTH-1:0] fval_r;
  logic [WIDTH-1:0] hold_r;
  logic             held_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underlying <= '0;
      fval_r     <= '0;
      hold_r     <= '0;
      held_r     <= 1'b0;
      forced     <= 1'b0;
    end else begin
      if (func_en) underlying <= func_d;
      if (force_set) begin
        forced <= 1'b1;
        fval_r <= force_val;
        held_r <= 1'b0;
      end else if (release_cmd && forced) begin
        forced <= 1'b0;
        // Variable semantics: keep showing the forced value until the next
        // functional load; a load on the release edge itself wins.
        if (REG_SEMANTICS != 0) begin
          hold_r <= fval_r;
          held_r <= !func_en;
        end
      end else if (func_en) begin
        held_r <= 1'b0;
      end
    end
  end

  always_comb begin
    q = underlying;
    if (forced)      q = fval_r;
    else if (held_r) q = hold_r;
  end

endmodule

// File: rtl/force_release_ctrl.sv
// Host command responder applying force/release/read to a bank of
// forceable registers, one response per accepted command.
module force_release_ctrl
  import force_release_pkg::*;
#(
  parameter int unsigned NUM_SIG       = 4,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned IDX_W         = 4,
  parameter int unsigned REG_SEMANTICS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SIG-1:0]       func_en,
  input  logic [NUM_SIG*WIDTH-1:0] func_d,
  output logic [NUM_SIG*WIDTH-1:0] q,
  output logic [NUM_SIG-1:0]       forced,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [IDX_W-1:0]         cmd_idx,
  input  logic [WIDTH-1:0]         cmd_val,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_status,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_forced
);

  state_e                   state, state_nxt;
  op_e                      op_r;
  logic [IDX_W-1:0]         idx_r;
  logic [WIDTH-1:0]         val_r;
  logic [NUM_SIG-1:0]       sel;
  logic [NUM_SIG-1:0]       force_set;
  logic [NUM_SIG-1:0]       release_set;
  logic [NUM_SIG*WIDTH-1:0] underlying;
  logic [WIDTH-1:0]         sel_under;
  logic                     sel_forced;
  status_e                  status_nxt;

  for (genvar g = 0; g < NUM_SIG; g++) begin : g_cell
    forceable_reg_cell #(
      .WIDTH        (WIDTH),
      .REG_SEMANTICS(REG_SEMANTICS)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .func_en    (func_en[g]),
      .func_d     (func_d[g*WIDTH +: WIDTH]),
      .force_set  (force_set[g]),
      .force_val  (val_r),
      .release_cmd(release_set[g]),
      .q          (q[g*WIDTH +: WIDTH]),
      .forced     (forced[g]),
      .underlying (underlying[g*WIDTH +: WIDTH])
    );
  end

  // An index with no matching cell leaves sel all-zero, which is BAD_IDX.
  always_comb begin
    sel         = '0;
    sel_under   = '0;
    sel_forced  = 1'b0;
    force_set   = '0;
    release_set = '0;
    for (int unsigned i = 0; i < NUM_SIG; i++) begin
      if (idx_r == IDX_W'(i)) begin
        sel[i]     = 1'b1;
        sel_under  = func_en[i] ? func_d[i*WIDTH +: WIDTH] : underlying[i*WIDTH +: WIDTH];
        sel_forced = forced[i];
      end
    end
    if (sel == '0)             status_nxt = ST_BAD_IDX;
    else if (op_r == OP_RSVD)  status_nxt = ST_BAD_OP;
    else                       status_nxt = ST_OK;
    if (state == S_EXEC && status_nxt == ST_OK) begin
      if (op_r == OP_FORCE)   force_set   = sel;
      if (op_r == OP_RELEASE) release_set = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r       <= OP_FORCE;
      idx_r      <= '0;
      val_r      <= '0;
      rsp_status <= ST_OK;
      rsp_data   <= '0;
      rsp_forced <= 1'b0;
    end else begin
      if (cmd_ready && cmd_valid) begin
        op_r  <= op_e'(cmd_op);
        idx_r <= cmd_idx;
        val_r <= cmd_val;
      end
      if (state == S_EXEC) begin
        rsp_status <= status_nxt;
        rsp_data   <= (status_nxt == ST_OK && op_r == OP_READ) ? sel_under : '0;
        if (status_nxt == ST_OK && op_r == OP_FORCE)        rsp_forced <= 1'b1;
        else if (status_nxt == ST_OK && op_r == OP_RELEASE) rsp_forced <= 1'b0;
        else                                                rsp_forced <= sel_forced;
      end
    end
  end

endmodule

// File: tb/tb_force_release_ctrl.sv
// Randomized bench: variable-semantics and net-semantics instances share all
// inputs and are checked against a per-edge visible-value model.
module tb_force_release_ctrl;

  localparam int NUM = 4;
  localparam int W   = 8;
  localparam int IW  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NUM-1:0] func_en;
  logic [NUM*W-1:0] func_d;
  logic           cmd_valid, rsp_ready;
  logic [1:0]     cmd_op;
  logic [IW-1:0]  cmd_idx;
  logic [W-1:0]   cmd_val;

  logic [NUM*W-1:0] q_a, q_b;
  logic [NUM-1:0]   forced_a, forced_b;
  logic             cmd_ready_a, cmd_ready_b, rsp_valid_a, rsp_valid_b;
  logic [1:0]       rsp_status_a, rsp_status_b;
  logic [W-1:0]     rsp_data_a, rsp_data_b;
  logic             rsp_forced_a, rsp_forced_b;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state; m_vis[0] = variable semantics, m_vis[1] = net semantics
  logic [W-1:0] m_und [NUM];
  logic [W-1:0] m_fval[NUM];
  logic [W-1:0] m_vis [2][NUM];
  bit           m_forced[NUM];
  int           e_status;
  logic [W-1:0] e_data;
  bit           e_forced;

  logic [NUM-1:0] pin_mask, pin_en;
  logic [W-1:0]   pin_d[NUM];

  always #5 clk = ~clk;

  force_release_ctrl #(.NUM_SIG(NUM), .WIDTH(W), .IDX_W(IW), .REG_SEMANTICS(1)) dut (
    .clk(clk), .rst_n(rst_n), .func_en(func_en), .func_d(func_d), .q(q_a), .forced(forced_a),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .cmd_val(cmd_val), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status_a), .rsp_data(rsp_data_a), .rsp_forced(rsp_forced_a));

  force_release_ctrl #(.NUM_SIG(NUM), .WIDTH(W), .IDX_W(IW), .REG_SEMANTICS(0)) dut_net (
    .clk(clk), .rst_n(rst_n), .func_en(func_en), .func_d(func_d), .q(q_b), .forced(forced_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .cmd_val(cmd_val), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status_b), .rsp_data(rsp_data_b), .rsp_forced(rsp_forced_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_und[i] = '0; m_fval[i] = '0; m_forced[i] = 1'b0;
      m_vis[0][i] = '0; m_vis[1][i] = '0;
    end
  endtask

  task automatic model_edge(input bit apply, input int op, input int idx, input logic [W-1:0] val);
    bit ok;
    ok = apply && idx < NUM && op != 3;
    for (int i = 0; i < NUM; i++) begin
      bit tgt, rel;
      tgt = ok && idx == i;
      rel = tgt && op == 1 && m_forced[i];
      if (tgt && op == 0) begin
        m_forced[i] = 1'b1;
        m_fval[i]   = val;
      end else if (rel) begin
        m_forced[i] = 1'b0;
      end
      if (func_en[i]) m_und[i] = func_d[i*W +: W];
      for (int k = 0; k < 2; k++) begin
        if (m_forced[i])           m_vis[k][i] = m_fval[i];
        else if (func_en[i])       m_vis[k][i] = func_d[i*W +: W];
        else if (rel && k == 1)    m_vis[k][i] = m_und[i];
      end
    end
    if (apply) begin
      e_status = (idx >= NUM) ? 1 : (op == 3) ? 2 : 0;
      e_data   = '0;
      e_forced = 1'b0;
      if (idx < NUM) begin
        e_forced = m_forced[idx];
        if (e_status == 0 && op == 2) e_data = m_und[idx];
      end
    end
  endtask

  function automatic logic [NUM*W-1:0] exp_q(input int k);
    logic [NUM*W-1:0] r;
    for (int i = 0; i < NUM; i++) r[i*W +: W] = m_vis[k][i];
    return r;
  endfunction

  function automatic logic [NUM-1:0] exp_forced();
    logic [NUM-1:0] r;
    for (int i = 0; i < NUM; i++) r[i] = m_forced[i];
    return r;
  endfunction

  task automatic drive_func();
    func_en = (NUM'($urandom) & ~pin_mask) | (pin_en & pin_mask);
    for (int i = 0; i < NUM; i++)
      func_d[i*W +: W] = pin_mask[i] ? pin_d[i] : W'($urandom);
  endtask

  task automatic tick(input bit apply, input int op, input int idx, input logic [W-1:0] val);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(apply, op, idx, val);
    #1;
    check("q_var", 64'(q_a), 64'(exp_q(0)));
    check("q_net", 64'(q_b), 64'(exp_q(1)));
    check("forced_var", 64'(forced_a), 64'(exp_forced()));
    check("forced_net", 64'(forced_b), 64'(exp_forced()));
  endtask

  task automatic check_rsp(input string tag);
    check({tag, "_valid"},  64'(rsp_valid_a),  64'(1));
    check({tag, "_status"}, 64'(rsp_status_a), 64'(e_status));
    check({tag, "_data"},   64'(rsp_data_a),   64'(e_data));
    check({tag, "_forced"}, 64'(rsp_forced_a), 64'(e_forced));
    check({tag, "_status_net"}, 64'(rsp_status_b), 64'(e_status));
    check({tag, "_data_net"},   64'(rsp_data_b),   64'(e_data));
    check({tag, "_ready"},  64'(cmd_ready_a),  64'(0));
  endtask

  task automatic do_cmd(input int op, input int idx, input logic [W-1:0] val, input int stall,
                        input bit rst_in_resp, output int got_status, output logic [W-1:0] got_data,
                        output bit got_forced);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_idx = IW'(idx); cmd_val = val;
    drive_func();
    check("accept_ready", 64'(cmd_ready_a), 64'(1));
    tick(1'b0, 0, 0, '0);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_idx = IW'($urandom); cmd_val = W'($urandom);
    drive_func();
    check("exec_rsp_valid", 64'(rsp_valid_a), 64'(0));
    check("exec_ready", 64'(cmd_ready_a), 64'(0));
    tick(1'b1, op, idx, val);
    check_rsp("rsp");
    got_status = int'(rsp_status_a); got_data = rsp_data_a; got_forced = rsp_forced_a;
    if (rst_in_resp) begin
      rst_n = 1'b0;
      drive_func();
      tick(1'b0, 0, 0, '0);
      rst_n = 1'b1;
      check("rst_rsp_valid",  64'(rsp_valid_a),  64'(0));
      check("rst_rsp_status", 64'(rsp_status_a), 64'(0));
      check("rst_rsp_data",   64'(rsp_data_a),   64'(0));
      check("rst_rsp_forced", 64'(rsp_forced_a), 64'(0));
      check("rst_cmd_ready",  64'(cmd_ready_a),  64'(1));
      return;
    end
    rsp_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_idx = IW'($urandom_range(0, NUM-1)); cmd_val = W'($urandom);
      drive_func();
      tick(1'b0, 0, 0, '0);
      check_rsp("stall");
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drive_func();
    tick(1'b0, 0, 0, '0);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 64'(rsp_valid_a), 64'(0));
    check("post_cmd_ready", 64'(cmd_ready_a), 64'(1));
  endtask

  initial begin
    int st; logic [W-1:0] dt; bit fr;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_val = '0; rsp_ready = 1'b0;
    func_en = '0; func_d = '0; pin_mask = '0; pin_en = '0;
    for (int i = 0; i < NUM; i++) pin_d[i] = '0;
    model_reset();

    drive_func();
    tick(1'b0, 0, 0, '0);
    tick(1'b0, 0, 0, '0);
    check("reset_q", 64'(q_a), 64'(0));
    check("reset_forced", 64'(forced_a), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid_a), 64'(0));
    check("reset_rsp_status", 64'(rsp_status_a), 64'(0));
    check("reset_rsp_data", 64'(rsp_data_a), 64'(0));
    check("reset_rsp_forced", 64'(rsp_forced_a), 64'(0));
    check("reset_cmd_ready", 64'(cmd_ready_a), 64'(1));
    rst_n = 1'b1;

    // functional load and readback of register 0
    pin_mask = 4'b0001; pin_en = 4'b0001; pin_d[0] = 8'h11;
    drive_func();
    tick(1'b0, 0, 0, '0);
    check("load_q0", 64'(q_a[7:0]), 64'(8'h11));
    do_cmd(2, 0, '0, 0, 1'b0, st, dt, fr);
    check("read0_status", 64'(st), 64'(0));
    check("read0_data", 64'(dt), 64'(8'h11));
    check("read0_forced", 64'(fr), 64'(0));

    // force register 1 while its functional input toggles
    pin_mask = 4'b0010; pin_en = 4'b0010; pin_d[1] = 8'h01;
    do_cmd(0, 1, 8'hA5, 0, 1'b0, st, dt, fr);
    for (int t = 0; t < 6; t++) begin
      pin_d[1] = (t % 2 == 1) ? 8'h02 : 8'h01;
      drive_func();
      tick(1'b0, 0, 0, '0);
      check("forced_q1", 64'(q_a[15:8]), 64'(8'hA5));
    end
    pin_d[1] = 8'h02;
    do_cmd(2, 1, '0, 0, 1'b0, st, dt, fr);
    check("read1_under", 64'(dt), 64'(8'h02));
    check("read1_forced", 64'(fr), 64'(1));

    // release with no functional load: variable keeps A5, net shows underlying
    pin_en = 4'b0000;
    do_cmd(1, 1, '0, 0, 1'b0, st, dt, fr);
    check("release_forced", 64'(fr), 64'(0));
    check("rel_var_hold", 64'(q_a[15:8]), 64'(8'hA5));
    check("rel_net_under", 64'(q_b[15:8]), 64'(8'h02));
    drive_func();
    tick(1'b0, 0, 0, '0);
    check("rel_var_hold2", 64'(q_a[15:8]), 64'(8'hA5));
    pin_en = 4'b0010; pin_d[1] = 8'h3C;
    drive_func();
    tick(1'b0, 0, 0, '0);
    check("rel_var_load", 64'(q_a[15:8]), 64'(8'h3C));
    check("rel_net_load", 64'(q_b[15:8]), 64'(8'h3C));

    // re-force overwrite, then release coinciding with a functional load
    do_cmd(0, 1, 8'h5A, 0, 1'b0, st, dt, fr);
    do_cmd(0, 1, 8'hC3, 0, 1'b0, st, dt, fr);
    check("reforce_q1", 64'(q_a[15:8]), 64'(8'hC3));
    pin_d[1] = 8'h77;
    do_cmd(1, 1, '0, 0, 1'b0, st, dt, fr);
    check("rel_load_wins", 64'(q_a[15:8]), 64'(8'h77));
    do_cmd(1, 1, '0, 0, 1'b0, st, dt, fr);
    check("rel_unforced_ok", 64'(st), 64'(0));

    // error statuses
    pin_mask = '0;
    do_cmd(0, NUM, 8'hFF, 0, 1'b0, st, dt, fr);
    check("bad_idx", 64'(st), 64'(1));
    do_cmd(3, 0, 8'hFF, 0, 1'b0, st, dt, fr);
    check("bad_op", 64'(st), 64'(2));
    do_cmd(3, NUM, 8'hFF, 0, 1'b0, st, dt, fr);
    check("bad_idx_prio", 64'(st), 64'(1));
    do_cmd(0, 15, 8'hFF, 0, 1'b0, st, dt, fr);
    check("bad_idx_max", 64'(st), 64'(1));

    // response back-pressure with a competing command offered
    do_cmd(2, 3, '0, 5, 1'b0, st, dt, fr);

    for (int n = 0; n < 150; n++) begin
      int op, idx;
      op  = $urandom_range(0, 3);
      idx = ($urandom_range(0, 7) == 0) ? $urandom_range(NUM, 15) : $urandom_range(0, NUM-1);
      do_cmd(op, idx, W'($urandom), $urandom_range(0, 3), 1'b0, st, dt, fr);
      if ($urandom_range(0, 3) == 0) begin
        drive_func();
        tick(1'b0, 0, 0, '0);
      end
    end

    // reset while a response is pending
    do_cmd(0, 2, 8'h99, 0, 1'b1, st, dt, fr);
    check("rst_q", 64'(q_a), 64'(0));
    check("rst_forced", 64'(forced_a), 64'(0));
    pin_mask = 4'b0100; pin_en = 4'b0000;
    do_cmd(2, 2, '0, 0, 1'b0, st, dt, fr);
    check("after_rst_status", 64'(st), 64'(0));
    check("after_rst_forced", 64'(fr), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/force_release_ctrl.md
Name: force_release_ctrl

Overview:
- Host-facing responder that implements force/release semantics for a bank of NUM_SIG clocked registers, the design-side counterpart of a host that issues force, release and readback commands.
- Each register is loaded each cycle from its functional input when enabled.
- A command port lets the host override any register's visible value, release it, or read back its state, with one response per command.
- Sits between the simulation-control bridge and the design logic whose state is being forced.

Parameters:
- NUM_SIG, 4, number of forceable registers (1..16)
- WIDTH, 8, bits per register
- IDX_W, 4, command index width; must satisfy 2**IDX_W >= NUM_SIG
- REG_SEMANTICS, 1, 1 = release keeps the forced value until the next functional load (variable semantics); 0 = release reverts immediately to the functional value (net semantics)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- func_en  in  NUM_SIG  per-register functional load enable
- func_d  in  NUM_SIG*WIDTH  functional next values, packed, index 0 in LSBs
- q  out  NUM_SIG*WIDTH  visible register values, packed
- forced  out  NUM_SIG  per-register force-active flags
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_op  in  2  0=FORCE 1=RELEASE 2=READ 3=reserved
- cmd_idx  in  IDX_W  target register
- cmd_val  in  WIDTH  force value (FORCE only)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_status  out  2  0=OK 1=BAD_IDX 2=BAD_OP
- rsp_data  out  WIDTH  READ: underlying functional value; otherwise 0
- rsp_forced  out  1  force flag of the target after the command

Behaviour:
- Reset (rst_n low at a clk edge): q=0, underlying=0, forced=0, rsp_valid=0, rsp_status=0, rsp_data=0, rsp_forced=0, FSM=IDLE. A reset asserted mid-command drops the command and any pending response.
- Per register: underlying loads func_d[i] on the clk edge when func_en[i]=1. Underlying always updates, including while forced.
- Visible value: when forced[i]=1, q[i]=force_val[i]; otherwise q[i]=hold[i]. hold[i] tracks underlying except in the REG_SEMANTICS=1 post-release case below.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch op/idx/val and go to EXEC.
  - EXEC: cmd_ready=0. Apply the command on this edge, build the response, go to RESP.
  - RESP: rsp_valid=1, outputs stable. When rsp_ready=1, go to IDLE.
- Latency: accept edge to rsp_valid is 2 edges. A new command is accepted at the earliest in the cycle after the response handshake. At most one command is outstanding.
- FORCE: forced[i]<=1, force_val[i]<=cmd_val. q reflects the new value at the EXEC edge. Re-forcing a register that is already forced overwrites force_val.
- RELEASE:
  - REG_SEMANTICS=1: hold[i]<=force_val[i] and forced[i]<=0. q keeps the forced value until the next edge with func_en[i]=1, then follows underlying again.
  - REG_SEMANTICS=0: forced[i]<=0 and q=underlying from the next cycle.
  - Releasing a register that is not forced returns OK with no effect.
- READ: rsp_data=underlying[i] as sampled at the EXEC edge (post-load). No state change.
- cmd_idx >= NUM_SIG: status BAD_IDX, no state change. cmd_op=3: status BAD_OP, no state change. BAD_IDX takes priority over BAD_OP.
- Simultaneous events:
  - FORCE and func_en on the same register in the EXEC cycle: underlying loads func_d, q shows cmd_val.
  - RELEASE (REG_SEMANTICS=1) and func_en in the EXEC cycle: the functional load wins and q=func_d on the next cycle.
- Unselected registers are never disturbed by commands.

Decomposition:
- Package force_release_pkg: op enum (FORCE/RELEASE/READ/RSVD), status enum (OK/BAD_IDX/BAD_OP), FSM state enum.
- One natural sub-module, forceable_reg_cell: one register's underlying/hold/force_val/forced storage and output mux. Parameters WIDTH and REG_SEMANTICS. Inputs: clk, rst_n, func_en, func_d, force_set, force_val, release.
- Top-level force_release_ctrl holds the FSM, the decode and NUM_SIG cell instances.

Test Plan:
- Reset, then func_en[0]=1 with func_d=8'h11 -> q[0]=8'h11, forced=0. READ idx0 -> rsp OK, data 8'h11, rsp_forced=0, rsp_valid 2 edges after accept.
- FORCE idx1 val 8'hA5 while func_d[1] toggles 8'h01/8'h02 every cycle -> q[1]=8'hA5 constantly, forced[1]=1. READ idx1 -> data tracks underlying (8'h01 or 8'h02).
- REG_SEMANTICS=1: force 8'hA5, hold func_en[1]=0, RELEASE -> q[1] stays 8'hA5. Then func_en[1]=1 with 8'h3C -> q[1]=8'h3C next cycle. With REG_SEMANTICS=0 the same sequence gives q[1]=underlying on the cycle after EXEC.
- cmd_idx=NUM_SIG -> BAD_IDX and q unchanged. cmd_op=3, idx 0 -> BAD_OP. cmd_op=3, idx=NUM_SIG -> BAD_IDX.
- Hold rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0, a new cmd_valid is not accepted. Release the stall -> next command accepted.
- Force idx2, then pull rst_n low while in RESP -> all outputs 0 and forced=0. The first command after reset is accepted normally.
